global_mem_arbiter: RTL and testbench
=====================================

GLOBAL_MEM_ARBITER -- requirements
Module: global_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of core requesters sharing global memory.
REQ-002 SHALL have parameter GLOBAL_BASE, default 32'h80000000, first byte address of global memory.
REQ-003 SHALL have parameter GLOBAL_SIZE, default 32'd1048576, global memory size in bytes.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum cycles to wait for a memory response.
REQ-005 SHALL have port clock, input, 1, sole clock; all logic on its posedge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-core request valid.
REQ-008 SHALL have port req_ready, output, NUM_REQ, per-core request accept, one-hot or zero.
REQ-009 SHALL have port req_we, input, NUM_REQ, per-core write flag.
REQ-010 SHALL have port req_size, input, NUM_REQ x 2, access size: 0=u8, 1=u16, 2=u32, 3=u64.
REQ-011 SHALL have port req_addr, input, NUM_REQ x 64, byte address.
REQ-012 SHALL have port req_wdata, input, NUM_REQ x 64, write data, LSB-aligned.
REQ-013 SHALL have port rsp_valid, output, NUM_REQ, one-cycle response pulse to the owning core.
REQ-014 SHALL have port rsp_rdata, output, 64, read data, LSB-aligned and zero-extended.
REQ-015 SHALL have port rsp_err, output, 1, error flag, qualified by rsp_valid.
REQ-016 SHALL have memory-side ports mem_valid (out, 1), mem_ready (in, 1), mem_we (out, 1), mem_addr (out, 32, offset from GLOBAL_BASE, 8-byte aligned), mem_be (out, 8), mem_wdata (out, 64), mem_rvalid (in, 1), mem_rdata (in, 64).

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, ERR.
REQ-018 In IDLE with any req_valid, SHALL grant by round-robin starting at last_owner+1 mod NUM_REQ, pulse req_ready[g] for exactly one cycle, and latch that request.
REQ-019 After accept, a legal request SHALL go to ISSUE; an illegal one SHALL go to ERR.
REQ-020 Illegal means: addr below GLOBAL_BASE; addr+bytes-1 at or above GLOBAL_BASE+GLOBAL_SIZE; or addr not a multiple of the access size.
REQ-021 ISSUE SHALL hold mem_valid=1 with stable mem_* until mem_ready=1, then go to WAIT; earliest mem_valid is accept cycle +1.
REQ-022 mem_be SHALL have (1<<size) bits set starting at addr[2:0].
REQ-023 mem_wdata SHALL be req_wdata shifted left by addr[2:0]*8.
REQ-024 In WAIT, on mem_rvalid SHALL pulse rsp_valid[owner] with rsp_err=0 and return to IDLE.
REQ-025 On a read, rsp_rdata SHALL be mem_rdata >> addr[2:0]*8, masked to size; on a write, rsp_rdata SHALL be 0.
REQ-026 WAIT SHALL count cycles; on reaching TIMEOUT without mem_rvalid, SHALL respond rsp_err=1, rsp_rdata=0, and return to IDLE.
REQ-027 If mem_rvalid and timeout occur in the same cycle, mem_rvalid SHALL win.
REQ-028 ERR SHALL pulse rsp_valid[owner] with rsp_err=1 and rsp_rdata=0 for one cycle, issue no memory access, then return to IDLE.
REQ-029 last_owner SHALL update on every accept.
REQ-030 mem_rvalid outside WAIT SHALL be ignored.
REQ-031 At most one transaction SHALL be outstanding; req_ready SHALL be 0 outside IDLE.
REQ-032 rsp_valid to one core and req_ready to any core SHALL never assert in the same cycle.

Reset
REQ-033 Reset SHALL force IDLE, last_owner=NUM_REQ-1 (so core 0 has first priority), timeout counter 0, and all outputs 0.
REQ-034 Reset mid-transaction SHALL drop it silently: no rsp_valid and no further mem_valid.

Structure
REQ-035 Package global_arb_pkg SHALL hold the size enum (SZ_U8..SZ_U64), default GLOBAL_BASE/GLOBAL_SIZE constants, the latched-request struct, and the FSM state enum.
REQ-036 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req vector and last grant; output one-hot grant).

Verification
REQ-037 Single read: core1 u32 at 0x80000004, memory returns 0x11223344_AABBCCDD -> mem_be=0xF0, rsp_valid[1], rsp_rdata=0x11223344, rsp_err=0.
REQ-038 Contention: all three cores valid in the same cycle after reset -> grants in order 0,1,2 with exactly one outstanding; then core0 re-requests alongside core2 after the core2 grant -> core0 granted next.
REQ-039 Errors: u16 at 0x80000001 (misaligned) and u8 at 0x80100000 (out of range) -> rsp_err=1 and no mem_valid.
REQ-040 Timeout: mem never asserts rvalid -> rsp_err=1 exactly TIMEOUT cycles after entering WAIT; a second bench case with rvalid in that same cycle -> rsp_err=0.
REQ-041 Reset in WAIT, followed by a late mem_rvalid -> no rsp_valid, FSM in IDLE, core0 granted first.
REQ-042 Write: core2 u8 0xA5 at 0x80000007 -> mem_be=0x80, mem_wdata[63:56]=0xA5, rsp_rdata=0.

Source files
------------

// File: rtl/global_mem_arbiter_pkg.sv
// Shared types for the global memory arbiter: access sizes, FSM states,
// the latched request record and small size helpers.
package global_arb_pkg;

  typedef enum logic [1:0] {
    SZ_U8  = 2'd0,
    SZ_U16 = 2'd1,
    SZ_U32 = 2'd2,
    SZ_U64 = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ERR
  } state_e;

  localparam logic [31:0] DEF_GLOBAL_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_GLOBAL_SIZE = 32'd1048576;

  // Offset is relative to GLOBAL_BASE; only legal requests ever reach memory.
  typedef struct packed {
    logic        we;
    size_e       size;
    logic [31:0] off;
    logic [63:0] wdata;
  } req_t;

  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

  function automatic logic [63:0] size_mask(input size_e sz);
    case (sz)
      SZ_U8:   return 64'h0000_0000_0000_00FF;
      SZ_U16:  return 64'h0000_0000_0000_FFFF;
      SZ_U32:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/global_mem_arbiter_rr.sv
// Round-robin grant: search starts one past the last granted index.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IDX_W'((int'(last) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/global_mem_arbiter.sv
// Shares one global memory port among NUM_REQ cores, one transaction at a
// time, with range/alignment checking and a response timeout.
module global_mem_arbiter
  import global_arb_pkg::*;
#(
  parameter int          NUM_REQ     = 3,
  parameter logic [31:0] GLOBAL_BASE = DEF_GLOBAL_BASE,
  parameter logic [31:0] GLOBAL_SIZE = DEF_GLOBAL_SIZE,
  parameter int          TIMEOUT     = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ-1:0][1:0]  req_size,
  input  logic [NUM_REQ-1:0][63:0] req_addr,
  input  logic [NUM_REQ-1:0][63:0] req_wdata,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [63:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [7:0]               mem_be,
  output logic [63:0]              mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [63:0]              mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  req_t             req_q;
  logic [IDX_W-1:0] owner_q, last_q, gidx;
  logic [CNT_W-1:0] cnt_q;
  logic [NUM_REQ-1:0] grant;
  logic             accept, sel_legal;
  size_e            sel_size;
  logic [63:0]      sel_addr, bytes64, rd_shift;
  logic [64:0]      sel_end, limit;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gidx = IDX_W'(i);
    end
  end

  // End address is computed one bit wider so a request near 2^64 cannot wrap.
  always_comb begin
    sel_size  = size_e'(req_size[gidx]);
    sel_addr  = req_addr[gidx];
    bytes64   = 64'(size_bytes(sel_size));
    sel_end   = {1'b0, sel_addr} + {1'b0, bytes64} - 65'd1;
    limit     = 65'(GLOBAL_BASE) + 65'(GLOBAL_SIZE);
    sel_legal = (sel_addr >= 64'(GLOBAL_BASE)) && (sel_end < limit) &&
                ((sel_addr & (bytes64 - 64'd1)) == 64'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q  <= gidx;
        owner_q <= gidx;
      end
      cnt_q <= (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      req_q <= '{we:    req_we[gidx],
                 size:  sel_size,
                 off:   32'(sel_addr - 64'(GLOBAL_BASE)),
                 wdata: req_wdata[gidx]};
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    rd_shift  = mem_rdata >> {req_q.off[2:0], 3'b000};
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          req_ready = grant;
          state_d   = sel_legal ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE: begin
        mem_valid = 1'b1;
        mem_we    = req_q.we;
        mem_addr  = {req_q.off[31:3], 3'b000};
        mem_be    = 8'((9'd1 << size_bytes(req_q.size)) - 9'd1) << req_q.off[2:0];
        mem_wdata = req_q.wdata << {req_q.off[2:0], 3'b000};
        if (mem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response arriving in the timeout cycle still counts as success.
        if (mem_rvalid) begin
          rsp_valid[owner_q] = 1'b1;
          rsp_rdata          = req_q.we ? 64'd0 : (rd_shift & size_mask(req_q.size));
          state_d            = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rsp_valid[owner_q] = 1'b1;
          rsp_err            = 1'b1;
          state_d            = S_IDLE;
        end
      end
      default: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_err            = 1'b1;
        state_d            = S_IDLE;
      end
    endcase
    if (reset) begin
      accept    = 1'b0;
      req_ready = '0;
      rsp_valid = '0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
    end
  end

endmodule

// File: tb/tb_global_mem_arbiter.sv
// Directed bench for global_mem_arbiter with hand-computed expectations.
module tb_global_mem_arbiter;

  localparam int TO = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [2:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [2:0][1:0]   req_size;
  logic [2:0][63:0]  req_addr, req_wdata;
  logic [63:0]       rsp_rdata, mem_wdata, mem_rdata;
  logic              rsp_err, mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0]       mem_addr;
  logic [7:0]        mem_be;

  int n_vec = 0;
  int n_err = 0;
  int mv_cnt = 0;
  int viol = 0;

  always #5 clock = ~clock;

  global_mem_arbiter #(.NUM_REQ(3), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always @(negedge clock) begin
    if (mem_valid) mv_cnt++;
    if ((|rsp_valid) && (|req_ready)) viol++;
    if ($countones(req_ready) > 1) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int core, input logic we, input logic [1:0] sz,
                         input logic [63:0] addr, input logic [63:0] wd);
    req_we[core]    = we;
    req_size[core]  = sz;
    req_addr[core]  = addr;
    req_wdata[core] = wd;
    req_valid[core] = 1'b1;
  endtask

  task automatic accept(input int core, input logic [2:0] exp);
    @(negedge clock);
    chk("grant", {61'd0, req_ready}, {61'd0, exp});
    @(posedge clock); #1;
    req_valid[core] = 1'b0;
  endtask

  task automatic mem_phase(input logic [7:0] be, input logic [31:0] addr,
                           input logic [63:0] wd, input logic we, input logic [63:0] rd,
                           input logic [2:0] who, input logic [63:0] exp_rd);
    @(negedge clock);
    chk("mem_valid", {63'd0, mem_valid}, 64'd1);
    chk("mem_be", {56'd0, mem_be}, {56'd0, be});
    chk("mem_addr", {32'd0, mem_addr}, {32'd0, addr});
    chk("mem_wdata", mem_wdata, wd);
    chk("mem_we", {63'd0, mem_we}, {63'd0, we});
    chk("busy_ready", {61'd0, req_ready}, 64'd0);
    @(posedge clock); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(negedge clock);
    chk("rsp_valid", {61'd0, rsp_valid}, {61'd0, who});
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", {63'd0, rsp_err}, 64'd0);
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic err_case(input int core, input logic [1:0] sz, input logic [63:0] addr);
    int mv0;
    mv0 = mv_cnt;
    set_req(core, 1'b0, sz, addr, 64'd0);
    accept(core, 3'(1 << core));
    @(negedge clock);
    chk("err_vld", {61'd0, rsp_valid}, {61'd0, 3'(1 << core)});
    chk("err_flag", {63'd0, rsp_err}, 64'd1);
    chk("err_rdata", rsp_rdata, 64'd0);
    @(posedge clock); #1;
    chk("err_nomem", 64'(mv_cnt - mv0), 64'd0);
  endtask

  task automatic timeout_case(input int core, input logic [63:0] addr, input logic with_rv,
                              input logic [63:0] exp_rd, input logic exp_err);
    int early;
    early = 0;
    set_req(core, 1'b0, 2'd2, addr, 64'd0);
    accept(core, 3'(1 << core));
    @(negedge clock);
    chk("to_issue", {63'd0, mem_valid}, 64'd1);
    @(posedge clock); #1;
    for (int k = 0; k < TO; k++) begin
      @(negedge clock);
      if (rsp_valid != 3'd0) early++;
      @(posedge clock); #1;
      if (with_rv && k == TO - 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF_CAFE_F00D;
      end
    end
    @(negedge clock);
    chk("to_early", 64'(early), 64'd0);
    chk("to_vld", {61'd0, rsp_valid}, {61'd0, 3'(1 << core)});
    chk("to_err", {63'd0, rsp_err}, {63'd0, exp_err});
    chk("to_rdata", rsp_rdata, exp_rd);
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    req_valid = 3'b111;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_ready", {61'd0, req_ready}, 64'd0);
    chk("rst_rsp", {61'd0, rsp_valid}, 64'd0);
    chk("rst_mem", {63'd0, mem_valid}, 64'd0);
    chk("rst_be", {56'd0, mem_be}, 64'd0);
    chk("rst_err", {63'd0, rsp_err}, 64'd0);
    @(posedge clock); #1;
    req_valid = '0;
    reset = 1'b0;

    // contention: all three cores at once
    for (int c = 0; c < 3; c++) set_req(c, 1'b0, 2'd0, 64'h8000_0000 + 64'(8 * c), 64'd0);
    accept(0, 3'b001);
    mem_phase(8'h01, 32'h0, 64'd0, 1'b0, 64'h50, 3'b001, 64'h50);
    accept(1, 3'b010);
    mem_phase(8'h01, 32'h8, 64'd0, 1'b0, 64'h51, 3'b010, 64'h51);
    accept(2, 3'b100);
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    mem_phase(8'h01, 32'h10, 64'd0, 1'b0, 64'h52, 3'b100, 64'h52);
    accept(0, 3'b001);
    req_valid[1] = 1'b1;
    mem_phase(8'h01, 32'h0, 64'd0, 1'b0, 64'h60, 3'b001, 64'h60);
    accept(1, 3'b010);
    mem_phase(8'h01, 32'h8, 64'd0, 1'b0, 64'h61, 3'b010, 64'h61);
    accept(2, 3'b100);
    mem_phase(8'h01, 32'h10, 64'd0, 1'b0, 64'h62, 3'b100, 64'h62);

    // single u32 read on core1, with a two-cycle memory stall
    set_req(1, 1'b0, 2'd2, 64'h8000_0004, 64'd0);
    accept(1, 3'b010);
    mem_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clock);
      chk("stall_vld", {63'd0, mem_valid}, 64'd1);
      chk("stall_be", {56'd0, mem_be}, 64'hF0);
      @(posedge clock); #1;
    end
    mem_ready = 1'b1;
    mem_phase(8'hF0, 32'h0, 64'd0, 1'b0, 64'h1122_3344_AABB_CCDD, 3'b010, 64'h1122_3344);

    // u8 write on core2 into the top byte lane
    set_req(2, 1'b1, 2'd0, 64'h8000_0007, 64'hA5);
    accept(2, 3'b100);
    mem_phase(8'h80, 32'h0, 64'hA500_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
              3'b100, 64'd0);

    // u16 read at lane 2, u64 read in the last legal doubleword
    set_req(0, 1'b0, 2'd1, 64'h8000_0102, 64'd0);
    accept(0, 3'b001);
    mem_phase(8'h0C, 32'h100, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 3'b001, 64'h89AB);
    set_req(1, 1'b0, 2'd3, 64'h800F_FFF8, 64'd0);
    accept(1, 3'b010);
    mem_phase(8'hFF, 32'h000F_FFF8, 64'd0, 1'b0, 64'hFEDC_BA98_7654_3210, 3'b010,
              64'hFEDC_BA98_7654_3210);

    // illegal requests
    err_case(0, 2'd1, 64'h8000_0001);
    err_case(1, 2'd0, 64'h8010_0000);
    err_case(2, 2'd0, 64'h7FFF_FFFF);

    // timeout, then timeout coinciding with rvalid
    timeout_case(1, 64'h8000_0000, 1'b0, 64'd0, 1'b1);
    timeout_case(2, 64'h8000_0008, 1'b1, 64'hCAFE_F00D, 1'b0);

    // rvalid while idle is ignored
    mem_rvalid = 1'b1;
    @(negedge clock);
    chk("idle_rv", {61'd0, rsp_valid}, 64'd0);
    @(posedge clock); #1;
    mem_rvalid = 1'b0;

    // reset while waiting on memory
    set_req(0, 1'b0, 2'd2, 64'h8000_0020, 64'd0);
    accept(0, 3'b001);
    @(negedge clock);
    chk("rw_issue", {63'd0, mem_valid}, 64'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rw_rst_rsp", {61'd0, rsp_valid}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h1234;
    @(negedge clock);
    chk("rw_late_rsp", {61'd0, rsp_valid}, 64'd0);
    chk("rw_late_mem", {63'd0, mem_valid}, 64'd0);
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    set_req(0, 1'b0, 2'd2, 64'h8000_0020, 64'd0);
    set_req(1, 1'b0, 2'd2, 64'h8000_0028, 64'd0);
    accept(0, 3'b001);
    req_valid = '0;
    mem_phase(8'h0F, 32'h20, 64'd0, 1'b0, 64'h9999_8888_7777_6666, 3'b001, 64'h7777_6666);

    chk("overlap", 64'(viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
